nnacc_mem_seq: RTL and testbench

Word-transfer sequencer that drives the NICE memory-interface stage: it generates the phase code, byte offset and per-word handshakes for the memory interface.
- For one start command it loads LEN words of LHS and then LEN words of RHS into local buffers.
- It then triggers the compute engine and writes LEN result words back to DST.
- It sits between the NICE instruction decoder (start/len) and the memory interface. The local buffers feed the MAC array.

---
 rtl/nnacc_pkg.sv | 35 +++
 rtl/nnacc_word_buf.sv | 23 ++
 rtl/nnacc_mem_seq.sv | 147 ++++++++++++++
 tb/tb_nnacc_mem_seq.sv | 398 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nnacc_pkg.sv
// Shared phase codes, FSM state encoding and size defaults for the NICE
// NN-accelerator memory sequencer.
package nnacc_pkg;

  localparam int DEPTH_DEF = 16;
  localparam int LEN_W_DEF = 5;

  localparam logic [1:0] PH_IDLE = 2'b00;
  localparam logic [1:0] PH_LHS  = 2'b01;
  localparam logic [1:0] PH_RHS  = 2'b10;
  localparam logic [1:0] PH_DST  = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LREQ,
    S_LRSP,
    S_RREQ,
    S_RRSP,
    S_COMP,
    S_WREQ,
    S_WRSP,
    S_DONE
  } seq_state_t;

  // Phase code seen by the memory interface; COMP and DONE look idle to it.
  function automatic logic [1:0] phase_of(input seq_state_t s);
    case (s)
      S_LREQ, S_LRSP: phase_of = PH_LHS;
      S_RREQ, S_RRSP: phase_of = PH_RHS;
      S_WREQ, S_WRSP: phase_of = PH_DST;
      default:        phase_of = PH_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/nnacc_word_buf.sv
// DEPTH x 32 operand buffer: one synchronous write port, one asynchronous
// read port (a same-cycle read of the written address returns the old word).
module nnacc_word_buf #(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/nnacc_mem_seq.sv
// Word-transfer sequencer: loads LHS/RHS operand words, kicks the compute
// engine, then stores the result words. Optional NNACC_SEQ_TIMEOUT_EN adds a
// response watchdog that raises err and aborts to DONE.
module nnacc_mem_seq
  import nnacc_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int LEN_W = LEN_W_DEF,
  parameter int TIMEOUT = 255,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             nice_clk,
  input  logic             nice_rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [1:0]       state,
  output logic [31:0]      bias_addr,
  output logic             data_in_acq,
  input  logic             data_in_rdy,
  output logic             data_out_rdy,
  input  logic             data_out_acq,
  input  logic             mem_cmd_ready,
  input  logic [31:0]      mem_rdata,
  output logic [31:0]      mem_wdata,
  input  logic [IDX_W-1:0] lhs_rd_addr,
  input  logic [IDX_W-1:0] rhs_rd_addr,
  output logic [31:0]      lhs_rd_data,
  output logic [31:0]      rhs_rd_data,
  output logic             comp_start,
  input  logic             comp_done,
  output logic [IDX_W-1:0] res_rd_addr,
  input  logic [31:0]      res_rd_data
);

  seq_state_t       fsm, fsm_base, fsm_nx;
  logic [IDX_W-1:0] idx;
  logic [LEN_W-1:0] len_q, len_clamp;
  logic             busy_q, comp_first, last, accept, lhs_we, rhs_we;

  assign accept    = (fsm == S_IDLE) && start;
  assign len_clamp = (len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : len;
  assign last      = (LEN_W'(idx) == len_q - LEN_W'(1));

  always_comb begin
    fsm_base = fsm;
    case (fsm)
      S_IDLE: if (start) fsm_base = (len_clamp == '0) ? S_DONE : S_LREQ;
      S_LREQ: if (mem_cmd_ready) fsm_base = S_LRSP;
      S_LRSP: if (data_in_rdy) fsm_base = last ? S_RREQ : S_LREQ;
      S_RREQ: if (mem_cmd_ready) fsm_base = S_RRSP;
      S_RRSP: if (data_in_rdy) fsm_base = last ? S_COMP : S_RREQ;
      S_COMP: if (comp_done) fsm_base = S_WREQ;
      S_WREQ: if (mem_cmd_ready) fsm_base = S_WRSP;
      S_WRSP: if (data_out_acq) fsm_base = last ? S_DONE : S_WREQ;
      S_DONE: fsm_base = S_IDLE;
      default: fsm_base = S_IDLE;
    endcase
  end

`ifdef NNACC_SEQ_TIMEOUT_EN
  localparam int TCNT_W = $clog2(TIMEOUT + 1);

  logic [TCNT_W-1:0] tcnt;
  logic              in_wait, tmo, err_q;

  // Counter restarts whenever a wait state is (re)entered, including RRSP->COMP.
  assign in_wait = (fsm == S_LRSP) || (fsm == S_RRSP) || (fsm == S_COMP) || (fsm == S_WRSP);
  assign tmo     = in_wait && (fsm_base == fsm) && (tcnt == TCNT_W'(TIMEOUT - 1));
  assign fsm_nx  = tmo ? S_DONE : fsm_base;

  always_ff @(posedge nice_clk or negedge nice_rst_n) begin
    if (!nice_rst_n) begin
      tcnt  <= '0;
      err_q <= 1'b0;
    end else begin
      tcnt <= (in_wait && fsm_nx == fsm) ? tcnt + 1'b1 : '0;
      if (accept)   err_q <= 1'b0;
      else if (tmo) err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign fsm_nx = fsm_base;
  assign err    = 1'b0;
`endif

  always_ff @(posedge nice_clk or negedge nice_rst_n) begin
    if (!nice_rst_n) begin
      fsm        <= S_IDLE;
      idx        <= '0;
      len_q      <= '0;
      busy_q     <= 1'b0;
      comp_first <= 1'b0;
    end else begin
      fsm        <= fsm_nx;
      comp_first <= (fsm_nx == S_COMP) && (fsm != S_COMP);
      if (accept) begin
        len_q  <= len_clamp;
        busy_q <= 1'b1;
      end else if (fsm == S_DONE) begin
        busy_q <= 1'b0;
      end
      case (fsm)
        S_IDLE:         idx <= '0;
        S_LRSP, S_RRSP: if (data_in_rdy) idx <= last ? '0 : idx + 1'b1;
        S_WRSP:         if (data_out_acq) idx <= last ? '0 : idx + 1'b1;
        S_COMP:         if (comp_done) idx <= '0;
        default: ;
      endcase
    end
  end

  assign busy         = busy_q;
  assign done         = (fsm == S_DONE);
  assign state        = phase_of(fsm);
  assign data_in_acq  = (fsm == S_LREQ) || (fsm == S_RREQ);
  assign data_out_rdy = (fsm == S_WREQ);
  assign comp_start   = (fsm == S_COMP) && comp_first;
  assign bias_addr    = (phase_of(fsm) != PH_IDLE) ? 32'({idx, 2'b00}) : 32'd0;
  assign mem_wdata    = (fsm == S_WREQ) ? res_rd_data : 32'd0;
  assign res_rd_addr  = idx;
  assign lhs_we       = (fsm == S_LRSP) && data_in_rdy;
  assign rhs_we       = (fsm == S_RRSP) && data_in_rdy;

  nnacc_word_buf #(.DEPTH(DEPTH)) u_lhs_buf (
    .clk   (nice_clk),
    .we    (lhs_we),
    .waddr (idx),
    .wdata (mem_rdata),
    .raddr (lhs_rd_addr),
    .rdata (lhs_rd_data)
  );

  nnacc_word_buf #(.DEPTH(DEPTH)) u_rhs_buf (
    .clk   (nice_clk),
    .we    (rhs_we),
    .waddr (idx),
    .wdata (mem_rdata),
    .raddr (rhs_rd_addr),
    .rdata (rhs_rd_data)
  );

endmodule

// File: tb/tb_nnacc_mem_seq.sv
// Bench for nnacc_mem_seq: a randomized memory/compute responder plus a
// transaction-level reference model of the expected bus traffic and buffers.
module tb_nnacc_mem_seq;

`ifdef NNACC_SEQ_TIMEOUT_EN
  localparam int TB_TIMEOUT = 8;
`else
  localparam int TB_TIMEOUT = 255;
`endif

  logic        nice_clk = 1'b0;
  logic        nice_rst_n = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  len = '0;
  logic        busy, done, err, data_in_acq, data_out_rdy, comp_start;
  logic [1:0]  state;
  logic [31:0] bias_addr, mem_wdata, lhs_rd_data, rhs_rd_data, res_rd_data;
  logic        data_in_rdy = 1'b0, data_out_acq = 1'b0, mem_cmd_ready = 1'b0, comp_done = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [3:0]  lhs_rd_addr = '0, rhs_rd_addr = '0, res_rd_addr;
  logic [31:0] res_mem [16];

  assign res_rd_data = res_mem[res_rd_addr];

  always #5 nice_clk = ~nice_clk;

  nnacc_mem_seq #(.TIMEOUT(TB_TIMEOUT)) dut (
    .nice_clk(nice_clk), .nice_rst_n(nice_rst_n), .start(start), .len(len),
    .busy(busy), .done(done), .err(err), .state(state), .bias_addr(bias_addr),
    .data_in_acq(data_in_acq), .data_in_rdy(data_in_rdy),
    .data_out_rdy(data_out_rdy), .data_out_acq(data_out_acq),
    .mem_cmd_ready(mem_cmd_ready), .mem_rdata(mem_rdata), .mem_wdata(mem_wdata),
    .lhs_rd_addr(lhs_rd_addr), .rhs_rd_addr(rhs_rd_addr),
    .lhs_rd_data(lhs_rd_data), .rhs_rd_data(rhs_rd_data),
    .comp_start(comp_start), .comp_done(comp_done),
    .res_rd_addr(res_rd_addr), .res_rd_data(res_rd_data)
  );

  typedef struct {
    logic [1:0]  ph;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  int          checks = 0;
  int          failures = 0;
  txn_t        log_q[$];
  logic [31:0] vals_l [16];
  logic [31:0] vals_r [16];
  logic [31:0] lhs_old [16];
  int          n_cs, n_done, done_cyc, hold_cyc, bad_hold;
  logic [1:0]  cs_phase;

  function automatic int pick(input int p);
    return (p >= 0) ? p : int'($urandom_range(-p, 0));
  endfunction

  // Expected traffic: lq LHS reads, lq RHS reads, lq DST writes at word offsets.
  function automatic int model_diff(input int l);
    int   lq = (l > 16) ? 16 : l;
    int   d = 0;
    txn_t e;
    txn_t exp_q[$];
    for (int p = 0; p < 3; p++)
      for (int i = 0; i < lq; i++) begin
        e.ph    = 2'(p + 1);
        e.addr  = 32'(i * 4);
        e.wdata = (p == 2) ? res_mem[i] : 32'h0;
        exp_q.push_back(e);
      end
    if (exp_q.size() != log_q.size()) d++;
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      if (log_q[i].ph !== exp_q[i].ph || log_q[i].addr !== exp_q[i].addr ||
          (exp_q[i].ph == 2'b11 && log_q[i].wdata !== exp_q[i].wdata)) d++;
    return d;
  endfunction

  task automatic randomize_data();
    for (int i = 0; i < 16; i++) begin
      vals_l[i]  = $urandom;
      vals_r[i]  = $urandom;
      res_mem[i] = $urandom;
    end
  endtask

  // Issues one command and plays memory + compute engine until done (bounded).
  task automatic run_cmd(input int l, input int crdy, input int rsp, input int cdn,
                         input bit spurious, input bit poke);
    int          mode = 0, cnt = 0, ccnt = 0, k_l = 0, k_r = 0, guard = 0;
    bit          cwait = 0, poked = 0;
    logic [1:0]  rph = '0;
    logic [31:0] hold_addr = '0;
    txn_t        t;
    log_q.delete();
    n_cs = 0; n_done = 0; done_cyc = -1; hold_cyc = 0; bad_hold = 0; cs_phase = 2'b11;
    start = 1'b1; len = 5'(l);
    @(posedge nice_clk); #1;
    while (n_done == 0 && guard < 3000) begin
      start = 0; mem_cmd_ready = 0; data_in_rdy = 0; data_out_acq = 0; comp_done = 0;
      mem_rdata = $urandom;
      if (comp_start) begin n_cs++; cs_phase = state; cwait = 1; ccnt = pick(cdn); end
      if (cwait) begin
        if (ccnt == 0) begin comp_done = 1; cwait = 0; end else ccnt--;
      end
      if (done) begin n_done++; done_cyc = guard; end
      if (mode == 0 && (data_in_acq || data_out_rdy)) begin
        mode = 1; cnt = pick(crdy); hold_addr = bias_addr;
      end
      if (mode == 1) begin
        hold_cyc++;
        if (bias_addr !== hold_addr || !(data_in_acq || data_out_rdy)) bad_hold++;
        if (cnt == 0) begin
          mem_cmd_ready = 1;
          t.ph = state; t.addr = bias_addr; t.wdata = mem_wdata;
          log_q.push_back(t);
          rph = state; mode = 2; cnt = pick(rsp);
        end else begin
          cnt--;
          if (spurious) begin data_in_rdy = 1; data_out_acq = 1; end
        end
      end else if (mode == 2) begin
        if (poke && !poked && state == 2'b10) begin start = 1; len = 5'd3; poked = 1; end
        if (cnt == 0) begin
          mode = 0;
          if (rph == 2'b11) data_out_acq = 1;
          else begin
            data_in_rdy = 1;
            if (rph == 2'b01) begin
              mem_rdata = vals_l[k_l % 16];
              lhs_rd_addr = 4'(k_l);
              #1 lhs_old[k_l % 16] = lhs_rd_data;
              k_l++;
            end else begin
              mem_rdata = vals_r[k_r % 16];
              k_r++;
            end
          end
        end else cnt--;
      end
      @(posedge nice_clk); #1;
      guard++;
    end
    start = 0; mem_cmd_ready = 0; data_in_rdy = 0; data_out_acq = 0; comp_done = 0;
  endtask

  task automatic test_reset();
    nice_rst_n = 1'b0;
    repeat (2) @(posedge nice_clk);
    #1;
    checks++;
    if ({busy, done, err, state, data_in_acq, data_out_rdy, comp_start} !== 8'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=0", {busy, done, err, state, data_in_acq, data_out_rdy, comp_start});
    end
    checks++;
    if (bias_addr !== 32'd0 || mem_wdata !== 32'd0) begin
      failures++;
      $display("FAIL reset_bus bias=%0h wdata=%0h exp=0", bias_addr, mem_wdata);
    end
    nice_rst_n = 1'b1;
    @(posedge nice_clk); #1;
    checks++;
    if (busy !== 1'b0 || state !== 2'b00) begin
      failures++;
      $display("FAIL idle_after_reset busy=%b state=%b exp=0/00", busy, state);
    end
  endtask

  task automatic test_single_word();
    randomize_data();
    vals_l[0] = 32'hA5A5_0001;
    vals_r[0] = 32'hB6B6_0002;
    run_cmd(1, 0, 0, 0, 0, 0);
    checks++;
    if (log_q.size() !== 3) begin
      failures++; $display("FAIL single_txn_count got=%0d exp=3", log_q.size());
    end else begin
      checks++;
      if ({log_q[0].ph, log_q[1].ph, log_q[2].ph} !== 6'b01_10_11) begin
        failures++;
        $display("FAIL single_phases got=%b%b%b exp=011011", log_q[0].ph, log_q[1].ph, log_q[2].ph);
      end
    end
    checks++;
    if (model_diff(1) !== 0) begin failures++; $display("FAIL single_model diffs=%0d exp=0", model_diff(1)); end
    checks++;
    if (n_cs !== 1 || cs_phase !== 2'b00) begin
      failures++; $display("FAIL single_comp_start count=%0d phase=%b exp=1/00", n_cs, cs_phase);
    end
    checks++;
    if (n_done !== 1 || busy !== 1'b0) begin
      failures++; $display("FAIL single_done done=%0d busy=%b exp=1/0", n_done, busy);
    end
    lhs_rd_addr = 4'd0; rhs_rd_addr = 4'd0; #1;
    checks++;
    if (lhs_rd_data !== 32'hA5A5_0001) begin
      failures++; $display("FAIL single_lhs0 got=%0h exp=a5a50001", lhs_rd_data);
    end
    checks++;
    if (rhs_rd_data !== 32'hB6B6_0002) begin
      failures++; $display("FAIL single_rhs0 got=%0h exp=b6b60002", rhs_rd_data);
    end
  endtask

  task automatic test_full_buffer();
    randomize_data();
    for (int i = 0; i < 16; i++) vals_l[i] = 32'h100 + 32'(i);
    run_cmd(16, -2, -2, -3, 0, 0);
    checks++;
    if (log_q.size() !== 48) begin failures++; $display("FAIL full_txn_count got=%0d exp=48", log_q.size()); end
    checks++;
    if (model_diff(16) !== 0) begin failures++; $display("FAIL full_model diffs=%0d exp=0", model_diff(16)); end
    for (int i = 0; i < 16; i++) begin
      lhs_rd_addr = 4'(i); rhs_rd_addr = 4'(i); #1;
      checks++;
      if (lhs_rd_data !== vals_l[i] || rhs_rd_data !== vals_r[i]) begin
        failures++;
        $display("FAIL full_buf[%0d] lhs=%0h/%0h rhs=%0h/%0h", i, lhs_rd_data, vals_l[i], rhs_rd_data, vals_r[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    randomize_data();
    run_cmd(3, 3, -2, -1, 1, 0);
    checks++;
    if (hold_cyc !== 36 || bad_hold !== 0) begin
      failures++; $display("FAIL bp_hold cycles=%0d unstable=%0d exp=36/0", hold_cyc, bad_hold);
    end
    checks++;
    if (model_diff(3) !== 0) begin failures++; $display("FAIL bp_model diffs=%0d exp=0", model_diff(3)); end
    for (int i = 0; i < 3; i++) begin
      lhs_rd_addr = 4'(i); rhs_rd_addr = 4'(i); #1;
      checks++;
      if (lhs_rd_data !== vals_l[i] || rhs_rd_data !== vals_r[i]) begin
        failures++; $display("FAIL bp_buf[%0d] lhs=%0h/%0h rhs=%0h/%0h", i, lhs_rd_data, vals_l[i], rhs_rd_data, vals_r[i]);
      end
    end
  endtask

  task automatic test_len_zero_clamp();
    randomize_data();
    run_cmd(0, -1, -1, -1, 0, 0);
    checks++;
    if (done_cyc !== 0 || log_q.size() !== 0 || n_cs !== 0) begin
      failures++; $display("FAIL len0 done_cyc=%0d txns=%0d cs=%0d exp=0/0/0", done_cyc, log_q.size(), n_cs);
    end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL len0_busy got=%b exp=0", busy); end
    randomize_data();
    run_cmd(20, -1, -1, -1, 0, 0);
    checks++;
    if (log_q.size() !== 48 || model_diff(20) !== 0) begin
      failures++; $display("FAIL clamp txns=%0d diffs=%0d exp=48/0", log_q.size(), model_diff(20));
    end
  endtask

  task automatic test_start_while_busy();
    randomize_data();
    run_cmd(5, -1, -1, -1, 0, 1);
    checks++;
    if (model_diff(5) !== 0 || n_done !== 1) begin
      failures++; $display("FAIL busy_start diffs=%0d done=%0d exp=0/1", model_diff(5), n_done);
    end
    repeat (3) @(posedge nice_clk);
    #1;
    checks++;
    if (busy !== 1'b0 || state !== 2'b00) begin
      failures++; $display("FAIL busy_start_idle busy=%b state=%b exp=0/00", busy, state);
    end
  endtask

  task automatic test_same_addr_old_data();
    logic [31:0] prev [4];
    randomize_data();
    run_cmd(4, -1, -1, -1, 0, 0);
    for (int i = 0; i < 4; i++) prev[i] = vals_l[i];
    randomize_data();
    run_cmd(4, -1, -1, -1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (lhs_old[i] !== prev[i]) begin
        failures++; $display("FAIL rd_during_wr[%0d] got=%0h exp=%0h", i, lhs_old[i], prev[i]);
      end
    end
  endtask

  task automatic test_mid_reset();
    start = 1'b1; len = 5'd8;
    @(posedge nice_clk); #1;
    start = 1'b0; mem_cmd_ready = 1'b1;
    @(posedge nice_clk); #1;
    mem_cmd_ready = 1'b0; data_in_rdy = 1'b1; mem_rdata = 32'hDEAD_0000;
    @(posedge nice_clk); #1;
    data_in_rdy = 1'b0;
    checks++;
    if (bias_addr !== 32'h4 || data_in_acq !== 1'b1) begin
      failures++; $display("FAIL mid_second_word bias=%0h acq=%b exp=4/1", bias_addr, data_in_acq);
    end
    #2 nice_rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, state, data_in_acq} !== 4'b0 || bias_addr !== 32'd0) begin
      failures++; $display("FAIL async_abort busy=%b state=%b acq=%b bias=%0h exp=0", busy, state, data_in_acq, bias_addr);
    end
    #2 nice_rst_n = 1'b1;
    @(posedge nice_clk); #1;
    checks++;
    if (busy !== 1'b0 || state !== 2'b00) begin
      failures++; $display("FAIL post_abort_idle busy=%b state=%b exp=0/00", busy, state);
    end
  endtask

  task automatic test_random();
    int l, lq;
    for (int n = 0; n < 6; n++) begin
      randomize_data();
      l  = int'($urandom_range(20, 0));
      lq = (l > 16) ? 16 : l;
      run_cmd(l, -3, -3, -2, 1'($urandom % 2), 0);
      checks++;
      if (model_diff(l) !== 0 || n_done !== 1 || n_cs !== ((lq > 0) ? 1 : 0) || err !== 1'b0) begin
        failures++;
        $display("FAIL rand_cmd len=%0d diffs=%0d done=%0d cs=%0d err=%b", l, model_diff(l), n_done, n_cs, err);
      end
      for (int i = 0; i < lq; i++) begin
        lhs_rd_addr = 4'(i); rhs_rd_addr = 4'(i); #1;
        checks++;
        if (lhs_rd_data !== vals_l[i] || rhs_rd_data !== vals_r[i]) begin
          failures++; $display("FAIL rand_buf[%0d] lhs=%0h/%0h rhs=%0h/%0h", i, lhs_rd_data, vals_l[i], rhs_rd_data, vals_r[i]);
        end
      end
    end
  endtask

`ifdef NNACC_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    int wait_cyc = 0, guard = 0;
    bit seen = 0;
    start = 1'b1; len = 5'd2;
    @(posedge nice_clk); #1;
    start = 1'b0; mem_cmd_ready = 1'b1;
    while (!seen && guard < 60) begin
      if (done) seen = 1;
      else begin
        if (state == 2'b01 && !data_in_acq) wait_cyc++;
        @(posedge nice_clk); #1;
        guard++;
      end
    end
    mem_cmd_ready = 1'b0;
    checks++;
    if (!seen || err !== 1'b1 || wait_cyc !== 8) begin
      failures++; $display("FAIL timeout done=%0d err=%b wait=%0d exp=1/1/8", seen, err, wait_cyc);
    end
    @(posedge nice_clk); #1;
    checks++;
    if (busy !== 1'b0 || err !== 1'b1) begin
      failures++; $display("FAIL timeout_sticky busy=%b err=%b exp=0/1", busy, err);
    end
    start = 1'b1; len = 5'd0;
    @(posedge nice_clk); #1;
    start = 1'b0;
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL timeout_clear err=%b exp=0", err); end
    @(posedge nice_clk); #1;
  endtask
`else
  task automatic test_stall_no_err();
    randomize_data();
    run_cmd(1, 0, 30, 0, 0, 0);
    checks++;
    if (model_diff(1) !== 0 || n_done !== 1 || err !== 1'b0) begin
      failures++; $display("FAIL stall diffs=%0d done=%0d err=%b exp=0/1/0", model_diff(1), n_done, err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_word();
    test_full_buffer();
    test_backpressure();
    test_len_zero_clamp();
    test_start_while_busy();
    test_same_addr_old_data();
    test_mid_reset();
    test_random();
`ifdef NNACC_SEQ_TIMEOUT_EN
    test_timeout();
`else
    test_stall_no_err();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
